// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state codes and the next-state rule.
// Also used by the IR/DR cell modules downstream of the TAP.
package jtag_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      EX2_DR = 4'h0,
      EX1_DR = 4'h1,
      SH_DR  = 4'h2,
      PA_DR  = 4'h3,
      SEL_IR = 4'h4,
      UPD_DR = 4'h5,
      CAP_DR = 4'h6,
      SEL_DR = 4'h7,
      EX2_IR = 4'h8,
      EX1_IR = 4'h9,
      SH_IR  = 4'hA,
      PA_IR  = 4'hB,
      RTI    = 4'hC,
      UPD_IR = 4'hD,
      CAP_IR = 4'hE,
      TLR    = 4'hF
   } tap_state_e;

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      case (s)
         TLR:    return tms ? TLR    : RTI;
         RTI:    return tms ? SEL_DR : RTI;
         SEL_DR: return tms ? SEL_IR : CAP_DR;
         SEL_IR: return tms ? TLR    : CAP_IR;
         CAP_DR: return tms ? EX1_DR : SH_DR;
         SH_DR:  return tms ? EX1_DR : SH_DR;
         EX1_DR: return tms ? UPD_DR : PA_DR;
         PA_DR:  return tms ? EX2_DR : PA_DR;
         EX2_DR: return tms ? UPD_DR : SH_DR;
         UPD_DR: return tms ? SEL_DR : RTI;
         CAP_IR: return tms ? EX1_IR : SH_IR;
         SH_IR:  return tms ? EX1_IR : SH_IR;
         EX1_IR: return tms ? UPD_IR : PA_IR;
         PA_IR:  return tms ? EX2_IR : PA_IR;
         EX2_IR: return tms ? UPD_IR : SH_IR;
         UPD_IR: return tms ? SEL_DR : RTI;
         default: return TLR;
      endcase
   endfunction

endpackage

// File: rtl/jtag_sync.sv
// Multi-flop synchronizer bringing one asynchronous JTAG pin into the ICLK domain.
// RST_VAL sets the idle level the chain presents while and after reset.
module jtag_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller running entirely on ICLK, with TCK oversampled.
// Produces IR/DR cell strobes and the registered TDO.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       ICLK,
   input  logic       RST,
   input  logic       TCK,
   input  logic       TMS,
   input  logic       TDI,
   input  logic       tdo_ir,
   input  logic       tdo_dr,
   output logic       tdi_s,
   output logic       TDO,
   output logic       tdo_oe,
   output logic       shift_ir,
   output logic       clk_ir,
   output logic       update_ir,
   output logic       shift_dr,
   output logic       clk_dr,
   output logic       update_dr,
   output logic [3:0] tap_state,
   output logic       test_logic_reset
);

   logic tck_s;
   logic tms_s;
   logic tdi_sync;

   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tck (
      .clk (ICLK),
      .rst (RST),
      .d   (TCK),
      .q   (tck_s)
   );

   // TMS idles high so a reset never lets a stray 0 walk the FSM out of TLR.
   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_tms (
      .clk (ICLK),
      .rst (RST),
      .d   (TMS),
      .q   (tms_s)
   );

   jtag_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tdi (
      .clk (ICLK),
      .rst (RST),
      .d   (TDI),
      .q   (tdi_sync)
   );

   logic       tck_prev_q, tck_prev_d;
   logic       tck_rise_q, tck_rise_d;
   logic       tck_fall_q, tck_fall_d;
   tap_state_e state_q, state_d;
   logic       tdo_q, tdo_d;
   logic       tdo_oe_q, tdo_oe_d;

   always_comb begin
      tck_prev_d = tck_s;
      tck_rise_d = tck_s & ~tck_prev_q;
      tck_fall_d = ~tck_s & tck_prev_q;

      state_d = state_q;
      if (tck_rise_q) begin
         state_d = tap_next(state_q, tms_s);
      end

      // TDO launches on the falling TCK edge so the host samples it on the next rise.
      tdo_d    = tdo_q;
      tdo_oe_d = tdo_oe_q;
      if (tck_fall_q) begin
         if (state_q == SH_IR) begin
            tdo_d    = tdo_ir;
            tdo_oe_d = 1'b1;
         end else if (state_q == SH_DR) begin
            tdo_d    = tdo_dr;
            tdo_oe_d = 1'b1;
         end else begin
            tdo_oe_d = 1'b0;
         end
      end
   end

   always_ff @(posedge ICLK) begin
      if (RST) begin
         tck_prev_q <= 1'b0;
         tck_rise_q <= 1'b0;
         tck_fall_q <= 1'b0;
         state_q    <= TLR;
         tdo_q      <= 1'b0;
         tdo_oe_q   <= 1'b0;
      end else begin
         tck_prev_q <= tck_prev_d;
         tck_rise_q <= tck_rise_d;
         tck_fall_q <= tck_fall_d;
         state_q    <= state_d;
         tdo_q      <= tdo_d;
         tdo_oe_q   <= tdo_oe_d;
      end
   end

   // Strobes are masked by RST so a reset landing on a TCK edge never clocks a cell.
   assign shift_ir  = ~RST & (state_q == SH_IR);
   assign shift_dr  = ~RST & (state_q == SH_DR);
   assign clk_ir    = ~RST & tck_rise_q & ((state_q == CAP_IR) | (state_q == SH_IR));
   assign clk_dr    = ~RST & tck_rise_q & ((state_q == CAP_DR) | (state_q == SH_DR));
   assign update_ir = ~RST & tck_fall_q & (state_q == UPD_IR);
   assign update_dr = ~RST & tck_fall_q & (state_q == UPD_DR);

   assign tap_state        = state_q;
   assign test_logic_reset = RST | (state_q == TLR);
   assign TDO              = tdo_q;
   assign tdo_oe           = tdo_oe_q;
   assign tdi_s            = tdi_sync;

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

- IEEE 1149.1 TAP controller oversampling TCK/TMS/TDI on the system clock `ICLK`.
- Generates the single-cycle `clk_*` / `update_*` strobes and `shift_*` levels that drive the per-bit IR and DR cells. It also returns the serial chain output on `TDO`.
- Sits directly upstream of the instruction-register and data-register cell chains; everything runs in the `ICLK` domain, with no logic clocked by TCK.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for TCK/TMS/TDI (minimum 2).

Ports:
- `ICLK`  in  1  system clock; all logic on its rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `TCK`, `TMS`, `TDI`  in  1 each  raw JTAG pins, asynchronous to `ICLK`.
- `tdo_ir`  in  1  serial output of the IR chain.
- `tdo_dr`  in  1  serial output of the selected DR chain.
- `tdi_s`  out  1  synchronized TDI, fed to the chain heads.
- `TDO`  out  1  registered test data out.
- `tdo_oe`  out  1  TDO output enable.
- `shift_ir`, `clk_ir`, `update_ir`  out  1 each  IR cell controls.
- `shift_dr`, `clk_dr`, `update_dr`  out  1 each  DR cell controls.
- `tap_state`  out  4  current TAP state code.
- `test_logic_reset`  out  1  high while in TEST_LOGIC_RESET.

## Operation

Input synchronization:
- TCK, TMS and TDI each pass through a `SYNC_STAGES` flop chain.
- One further flop on TCK gives the registered edge flags `tck_rise` and `tck_fall`, each one `ICLK` wide.

State codes (16-state FSM):
- TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PA_DR=3, EX2_DR=0, UPD_DR=5.
- SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PA_IR=B, EX2_IR=8, UPD_IR=D.

Transitions, taken only in a cycle with `tck_rise`=1, using the synchronized TMS (written as TMS 0 / 1 below):
- TLR: 0 → RTI, 1 → TLR.
- RTI: 0 → RTI, 1 → SEL_DR.
- SEL_DR: 0 → CAP_DR, 1 → SEL_IR.
- SEL_IR: 0 → CAP_IR, 1 → TLR.
- CAP_x: 0 → SH_x, 1 → EX1_x.
- SH_x: 0 → SH_x, 1 → EX1_x.
- EX1_x: 0 → PA_x, 1 → UPD_x.
- PA_x: 0 → PA_x, 1 → EX2_x.
- EX2_x: 0 → SH_x, 1 → UPD_x.
- UPD_x: 0 → RTI, 1 → SEL_DR.

Outputs, all decoded from the current state register:
- `shift_ir` = (state==SH_IR); `shift_dr` = (state==SH_DR).
- `clk_ir` = `tck_rise` & state∈{CAP_IR, SH_IR}; `clk_dr` likewise for CAP_DR/SH_DR. Thus `shift_*` is valid in the same cycle as its strobe, and the state advances at the end of that cycle.
- `update_ir` = `tck_fall` & (state==UPD_IR); `update_dr` likewise.

TDO:
- On `tck_fall`: in SH_IR, TDO←`tdo_ir` and `tdo_oe`←1; in SH_DR, TDO←`tdo_dr` and `tdo_oe`←1; otherwise `tdo_oe`←0 and TDO holds its value.

Reset values (`RST`=1):
- state=TLR, TDO=0, `tdo_oe`=0.
- All strobes and `shift_*` =0; `test_logic_reset`=1.
- TCK synchronizer and edge flop =0; TMS synchronizer =1; TDI synchronizer =0.

Boundary conditions:
- Five consecutive TCK rises with TMS=1 reach TLR from any state.
- `RST` in mid-shift: the state is TLR on the next cycle and no `update_*` pulse is issued.
- If `tck_rise` and `RST` coincide, `RST` wins.
- TCK held static: state and outputs are frozen.

## Timing

- Pin edge of TCK → `tck_rise`/`tck_fall` asserted `SYNC_STAGES`+1 `ICLK` cycles later.
- TCK high and low times must each be ≥ `SYNC_STAGES`+2 `ICLK` periods; faster TCK is unsupported and its behaviour is undefined.
- TMS/TDI are sampled through the same-depth synchronizers, so they are aligned with `tck_rise`.
- `clk_*` and `update_*` pulses are exactly one `ICLK` wide, at most one per TCK edge.
- `tap_state` changes on the `ICLK` edge that ends the `tck_rise` cycle.
- TDO changes on the `ICLK` edge that ends the `tck_fall` cycle.

## Structure

- Package `jtag_pkg` holds:
  - the 16 state-code localparams;
  - the 4-bit state width constant.
  The IR/DR cell modules share this package.
- Sub-module `jtag_sync`: `SYNC_STAGES`-deep synchronizer with a reset value parameter, instantiated three times (TCK, TMS, TDI).
- FSM, strobe decode and TDO register stay in `jtag_tap_ctrl`.

## Test plan

- **Reset:** `RST`=1 for 1 cycle → `tap_state`=F, `test_logic_reset`=1, TDO=0, `tdo_oe`=0, all strobes 0.
- **IR scan:** from TLR, TMS 0,1,1,0,0 → `tap_state`=A. Then 4 TCKs with TMS 0,0,0,1 → `clk_ir` pulsed 5 times total (1 capture with `shift_ir`=0, 4 with `shift_ir`=1), state 9. Then TMS 1 → D, exactly one `update_ir` pulse on the following falling edge. Then TMS 0 → C.
- **Reset by TMS:** from SH_DR (2), five TCKs with TMS=1 → state F; no `update_dr` pulse before UPD_DR is reached.
- **TDO:** in SH_DR with `tdo_dr`=1, `tdo_ir`=0 → after `tck_fall`, TDO=1 and `tdo_oe`=1. After moving to RTI → `tdo_oe`=0 on the next `tck_fall`.
- **Reset mid-operation:** `RST` pulsed while in SH_IR coincident with `tck_rise` → state F next cycle, no `clk_ir` or `update_ir` pulse.
- **Pause path:** SH_DR → EX1 → PA (3 TCKs held) → EX2 → SH_DR → `clk_dr` pulses only in SH_DR/CAP_DR states, none during PA_DR.
